// File: rtl/protected_reg_arbiter.sv
// rtl/protected_reg_arbiter.sv - round-robin, ID-checked write controller for a protected register (optional macro PROT_ARB_VIOL_COUNT_EN)
module protected_reg_arbiter #(
   parameter int                NUM_REQ       = 4,
   parameter int                DATA_W        = 8,
   parameter int                ID_W          = 3,
   parameter logic [ID_W-1:0]   RESET_AUTH_ID = 3'h4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ID_W-1:0]   req_id,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REQ-1:0]        err,
   input  logic                      cfg_we,
   input  logic [ID_W-1:0]           cfg_id,
   input  logic                      cfg_lock,
   output logic                      cfg_locked,
   output logic                      cfg_err,
   output logic [DATA_W-1:0]         data_out,
   output logic [7:0]                viol_count
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

   state_t             state, next_state;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   win;
   logic               found;
   logic [PTR_W-1:0]   sel;
   logic [ID_W-1:0]    lat_id;
   logic [DATA_W-1:0]  lat_data;
   logic [ID_W-1:0]    auth_id;
   logic               id_match;

   // Winner search: first set req bit at or above ptr, wrapping at NUM_REQ
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
            found = 1'b1;
            win   = PTR_W'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

   assign id_match = (lat_id == auth_id);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state: a grant always takes IDLE -> CHECK -> RESP -> IDLE
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (found) next_state = CHECK;
         CHECK:   next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Grant latching, protected write and single-cycle ack/err pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr      <= '0;
         sel      <= '0;
         lat_id   <= '0;
         lat_data <= '0;
         data_out <= '0;
         ack      <= '0;
         err      <= '0;
      end else begin
         ack <= '0;
         err <= '0;
         if (state == IDLE && found) begin
            sel      <= win;
            lat_id   <= req_id[int'(win)*ID_W +: ID_W];
            lat_data <= req_data[int'(win)*DATA_W +: DATA_W];
            ptr      <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
         end
         if (state == CHECK) begin
            if (id_match) begin
               data_out <= lat_data;
               ack[sel] <= 1'b1;
            end else begin
               err[sel] <= 1'b1;
            end
         end
      end
   end

   // Config: auth_id writable until the sticky lock is set; auth_id is
   // sampled by CHECK before any same-edge update lands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         auth_id    <= RESET_AUTH_ID;
         cfg_locked <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         cfg_err <= cfg_we & cfg_locked;
         if (cfg_we && !cfg_locked) auth_id <= cfg_id;
         if (cfg_lock) cfg_locked <= 1'b1;
      end
   end

`ifdef PROT_ARB_VIOL_COUNT_EN
   // Saturating count of denied writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) viol_count <= 8'd0;
      else if (state == CHECK && !id_match && viol_count != 8'hFF)
         viol_count <= viol_count + 8'd1;
   end
`else
   assign viol_count = 8'd0;
`endif

endmodule

// File: tb/tb_protected_reg_arbiter.sv
// tb/tb_protected_reg_arbiter.sv - directed self-checking bench for protected_reg_arbiter
module tb_protected_reg_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int ID_W    = 3;
`ifdef PROT_ARB_VIOL_COUNT_EN
   localparam bit VIOL_EN = 1'b1;
`else
   localparam bit VIOL_EN = 1'b0;
`endif

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ID_W-1:0]   req_id;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        ack;
   logic [NUM_REQ-1:0]        err;
   logic                      cfg_we;
   logic [ID_W-1:0]           cfg_id;
   logic                      cfg_lock;
   logic                      cfg_locked;
   logic                      cfg_err;
   logic [DATA_W-1:0]         data_out;
   logic [7:0]                viol_count;

   int checks   = 0;
   int failures = 0;

   protected_reg_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .RESET_AUTH_ID(3'h4)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_id(req_id), .req_data(req_data),
      .ack(ack), .err(err), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_lock(cfg_lock),
      .cfg_locked(cfg_locked), .cfg_err(cfg_err), .data_out(data_out),
      .viol_count(viol_count)
   );

   always #5 clk = ~clk;

   // Present one request for exactly one sampling edge, then drop it
   task automatic issue(input int idx, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
      req = '0;
      req[idx] = 1'b1;
      req_id[idx*ID_W +: ID_W] = id;
      req_data[idx*DATA_W +: DATA_W] = d;
      @(negedge clk);
      req = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; req_id = '0; req_data = '0;
      cfg_we = 1'b0; cfg_id = '0; cfg_lock = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
      checks++; if (err !== 4'b0000) begin failures++; $display("FAIL reset_err got=%b exp=0000", err); end
      checks++; if (cfg_locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", cfg_locked); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
      checks++; if (viol_count !== 8'd0) begin failures++; $display("FAIL reset_viol got=%0d exp=0", viol_count); end
   endtask

   task automatic test_match();
      issue(0, 3'h4, 8'hA5);
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL match_early_ack got=%b exp=0000", ack); end
      @(negedge clk);
      checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL match_ack got=%b exp=0001", ack); end
      checks++; if (err !== 4'b0000) begin failures++; $display("FAIL match_err got=%b exp=0000", err); end
      checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL match_data got=%h exp=a5", data_out); end
      @(negedge clk);
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL match_ack_clear got=%b exp=0000", ack); end
      checks++; if (viol_count !== 8'd0) begin failures++; $display("FAIL match_viol got=%0d exp=0", viol_count); end
   endtask

   task automatic test_mismatch();
      issue(1, 3'h2, 8'h3C);
      @(negedge clk);
      checks++; if (err !== 4'b0010) begin failures++; $display("FAIL mismatch_err got=%b exp=0010", err); end
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL mismatch_ack got=%b exp=0000", ack); end
      checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL mismatch_data got=%h exp=a5", data_out); end
      checks++; if (viol_count !== (VIOL_EN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL mismatch_viol got=%0d exp=%0d", viol_count, VIOL_EN ? 1 : 0); end
      @(negedge clk);
      checks++; if (err !== 4'b0000) begin failures++; $display("FAIL mismatch_err_clear got=%b exp=0000", err); end
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      logic [NUM_REQ-1:0] exp_ack;
      // Grant to requester 3 first so the pointer wraps back to 0
      issue(3, 3'h4, 8'hC3);
      @(negedge clk);
      checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL rr_wrap_ack got=%b exp=1000", ack); end
      checks++; if (data_out !== 8'hC3) begin failures++; $display("FAIL rr_wrap_data got=%h exp=c3", data_out); end
      @(negedge clk);
      req = 4'b1111;
      req_id = {3'h4, 3'h4, 3'h4, 3'h4};
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int g = 0; g < 5; g++) begin
         exp_ack = '0;
         exp_ack[order[g]] = 1'b1;
         @(negedge clk);
         checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rr_gap_ack g=%0d got=%b exp=0000", g, ack); end
         @(negedge clk);
         checks++; if (ack !== exp_ack) begin failures++; $display("FAIL rr_ack g=%0d got=%b exp=%b", g, ack, exp_ack); end
         checks++; if (data_out !== 8'h10 + 8'(order[g])) begin failures++; $display("FAIL rr_data g=%0d got=%h exp=%h", g, data_out, 8'h10 + 8'(order[g])); end
         @(negedge clk);
      end
      req = '0;
      repeat (2) @(negedge clk);
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rr_idle_ack got=%b exp=0000", ack); end
   endtask

   task automatic test_cfg_lock();
      cfg_we = 1'b1; cfg_id = 3'h1; cfg_lock = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0; cfg_lock = 1'b0;
      checks++; if (cfg_locked !== 1'b1) begin failures++; $display("FAIL cfg_locked got=%b exp=1", cfg_locked); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_unlocked got=%b exp=0", cfg_err); end
      cfg_we = 1'b1; cfg_id = 3'h4;
      @(negedge clk);
      cfg_we = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_pulse got=%b exp=1", cfg_err); end
      @(negedge clk);
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_clear got=%b exp=0", cfg_err); end
      // Pointer is at 1 after the round-robin run; only requester 2 asks
      issue(2, 3'h4, 8'h77);
      @(negedge clk);
      checks++; if (err !== 4'b0100) begin failures++; $display("FAIL cfg_old_id_err got=%b exp=0100", err); end
      checks++; if (data_out !== 8'h10) begin failures++; $display("FAIL cfg_old_id_data got=%h exp=10", data_out); end
      @(negedge clk);
      issue(3, 3'h1, 8'h5A);
      @(negedge clk);
      checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL cfg_new_id_ack got=%b exp=1000", ack); end
      checks++; if (data_out !== 8'h5A) begin failures++; $display("FAIL cfg_new_id_data got=%h exp=5a", data_out); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      issue(0, 3'h1, 8'h99);
      rst = 1'b1;
      #1;
      checks++; if (cfg_locked !== 1'b0) begin failures++; $display("FAIL rstmid_locked got=%b exp=0", cfg_locked); end
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data_out); end
      @(negedge clk);
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rstmid_ack got=%b exp=0000", ack); end
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rstmid_data_hold got=%h exp=00", data_out); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rstmid_ack_after got=%b exp=0000", ack); end
      // Back in IDLE with reset auth_id 4
      issue(1, 3'h4, 8'h11);
      @(negedge clk);
      checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL rstmid_next_ack got=%b exp=0010", ack); end
      checks++; if (data_out !== 8'h11) begin failures++; $display("FAIL rstmid_next_data got=%h exp=11", data_out); end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      int err_pulses = 0;
      int ack_pulses = 0;
      req = 4'b0001;
      req_id = '0;
      req_data = {24'h0, 8'hEE};
      for (int c = 0; c < 900; c++) begin
         @(negedge clk);
         if (err[0]) err_pulses++;
         if (ack !== 4'b0000) ack_pulses++;
      end
      req = '0;
      repeat (3) @(negedge clk);
      checks++; if (err_pulses !== 300) begin failures++; $display("FAIL sat_err_pulses got=%0d exp=300", err_pulses); end
      checks++; if (ack_pulses !== 0) begin failures++; $display("FAIL sat_ack_pulses got=%0d exp=0", ack_pulses); end
      checks++; if (viol_count !== (VIOL_EN ? 8'd255 : 8'd0)) begin failures++; $display("FAIL sat_viol got=%0d exp=%0d", viol_count, VIOL_EN ? 255 : 0); end
      checks++; if (data_out !== 8'h11) begin failures++; $display("FAIL sat_data got=%h exp=11", data_out); end
   endtask

   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_round_robin();
      test_cfg_lock();
      test_reset_mid();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
